// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: N-digit common-anode 7-seg scanner with hex decode, blank/blink, guard and frame snapshot.
// Latency: an/seg/dp/frame_start are registered, one clock after the counter state that selects them.
// Backpressure: none; free-running scan. Optional build macro LEADING_ZERO_SUPPRESS_EN adds leading-zero suppression.
module seven_seg_scanner #(
  parameter int N_DIGITS     = 4,
  parameter int CLK_DIV      = 100000,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic [N_DIGITS-1:0]   blink_mask,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GUARD_END = DIV_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

  // Scan counters
  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] digit_idx;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;
  logic             slot_end;
  logic             snap;

  // Frame-coherent copies of the display inputs
  logic [4*N_DIGITS-1:0] shadow_data;
  logic [N_DIGITS-1:0]   shadow_dp;
  logic [N_DIGITS-1:0]   shadow_blank;
  logic [N_DIGITS-1:0]   shadow_blink;

  // Next values for the registered outputs
  logic [3:0]          cur_nib;
  logic                cur_supp;
  logic                digit_vis;
  logic                drive;
  logic [N_DIGITS-1:0] an_nxt;
  logic [6:0]          seg_nxt;
  logic                dp_nxt;

  // Standard hex glyphs, bit order g..a, active-low
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  assign slot_end = (div_cnt == DIV_LAST);
  assign snap     = slot_end && (digit_idx == IDX_LAST);

  // Slot prescaler and digit pointer; wraps to digit 0 after the last slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      digit_idx <= '0;
    end else if (slot_end) begin
      div_cnt   <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Capture the inputs at the end of the last slot so a whole frame shows one coherent set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '1;
      shadow_blink <= '0;
    end else if (snap) begin
      shadow_data  <= data;
      shadow_dp    <= dp_in;
      shadow_blank <= blank_mask;
      shadow_blink <= blink_mask;
    end
  end

  // Blink frame counter; advanced on the capture edge (one per frame_start) so a new
  // phase lands on the same slot as the new shadow values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (snap) begin
      if (blink_cnt == BLK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign cur_nib = shadow_data[{digit_idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_SUPPRESS_EN
  logic [N_DIGITS-1:0] lz_supp;
  logic                zero_run;

  // A digit is a leading zero when it and every digit above it are zero; digit 0 is never suppressed
  always_comb begin
    lz_supp  = '0;
    zero_run = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (shadow_data[4*i +: 4] == 4'h0);
      lz_supp[i] = zero_run;
    end
  end

  assign cur_supp = lz_supp[digit_idx];
`else
  assign cur_supp = 1'b0;
`endif

  // Visibility, guard phase and cathode pattern for the slot currently being scanned
  always_comb begin
    digit_vis = en && !shadow_blank[digit_idx]
                && !(shadow_blink[digit_idx] && !blink_phase)
                && (!cur_supp || shadow_dp[digit_idx]);
    drive     = digit_vis && (div_cnt >= GUARD_END);
    an_nxt    = '1;
    if (drive) begin
      an_nxt = ~(N_DIGITS'(1) << digit_idx);
    end
    seg_nxt = cur_supp ? 7'h7F : hex_glyph(cur_nib);
    dp_nxt  = !(drive && shadow_dp[digit_idx]);
  end

  // Output registers; reset drives every pin inactive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an          <= '1;
      seg         <= '1;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      an          <= an_nxt;
      seg         <= seg_nxt;
      dp          <= dp_nxt;
      frame_start <= snap;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: randomized inputs, per-cycle expected outputs queued by the
// driver from a frame/slot arithmetic model, popped and compared by an independent monitor.
module tb_seven_seg_scanner;

  localparam int N  = 4;
  localparam int CD = 8;
  localparam int GD = 2;
  localparam int BF = 2;
  localparam int FP = N * CD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_en = 1'b0;

  // Model: clocks elapsed since release, plus the shadow set belonging to the current frame
  int          t;
  logic [15:0] m_data;
  logic [3:0]  m_dp, m_blank, m_blink;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .N_DIGITS(N), .CLK_DIV(CD), .GUARD(GD), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .data(data), .dp_in(dp_in),
    .blank_mask(blank_mask), .blink_mask(blink_mask),
    .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  // Glyph from the lit-segment view (bit0 = a, 1 = lit), inverted for the active-low pins
  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] lit;
    case (v)
      4'h0: lit = 7'h3F;  4'h1: lit = 7'h06;  4'h2: lit = 7'h5B;  4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66;  4'h5: lit = 7'h6D;  4'h6: lit = 7'h7D;  4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F;  4'h9: lit = 7'h6F;  4'hA: lit = 7'h77;  4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39;  4'hD: lit = 7'h5E;  4'hE: lit = 7'h79;  default: lit = 7'h71;
    endcase
    return ~lit;
  endfunction

  task automatic model_reset();
    t       = 0;
    m_data  = '0;
    m_dp    = '0;
    m_blank = 4'hF;
    m_blink = '0;
  endtask

  // Expected outputs after the coming edge, from the current inputs and elapsed time
  task automatic model_edge();
    exp_t e;
    int   div, d, k;
    bit   phase, vis, supp, lit;
    div   = t % CD;
    d     = (t / CD) % N;
    k     = t / FP;
    phase = ((k / BF) % 2) == 0;
    supp  = 1'b0;
`ifdef LEADING_ZERO_SUPPRESS_EN
    supp  = (d != 0) && ((m_data >> (4 * d)) == 16'h0);
`endif
    vis   = en && !m_blank[d] && !(m_blink[d] && !phase);
    lit   = vis && (div >= GD) && (!supp || m_dp[d]);
    e.an  = lit ? ~(4'b0001 << d) : 4'hF;
    e.seg = supp ? 7'h7F : glyph(m_data[4*d +: 4]);
    e.dp  = !(lit && m_dp[d]);
    e.fs  = ((t + 1) % FP) == 0;
    exp_q.push_back(e);
    if (((t + 1) % FP) == 0) begin
      m_data  = data;
      m_dp    = dp_in;
      m_blank = blank_mask;
      m_blink = blink_mask;
    end
    t++;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic chk_reset_pins();
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_seg", {9'h0, seg}, 16'h007F);
    chk("rst_dp", {15'h0, dp}, 16'h0001);
    chk("rst_fs", {15'h0, frame_start}, 16'h0000);
  endtask

  // Called at posedge+2: queue the expectation for the next edge, then advance one clock
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic release_reset();
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  // Asynchronous reset in the middle of a frame
  task automatic mid_reset();
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk_reset_pins();
    @(posedge clk);
    #1;
    chk_reset_pins();
    #1;
    release_reset();
  endtask

  // Scoreboard monitor
  exp_t got_e;
  always @(posedge clk) begin
    #1;
    if (mon_en && !rst) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        got_e = exp_q.pop_front();
        if ({an, seg, dp, frame_start} !== got_e) begin
          errors++;
          $display("FAIL scan_out at %0t: an=%b seg=%b dp=%b fs=%b, expected an=%b seg=%b dp=%b fs=%b",
                   $time, an, seg, dp, frame_start, got_e.an, got_e.seg, got_e.dp, got_e.fs);
        end
      end
    end
  end

  // frame_start spacing: first pulse FP clocks after release, then every FP clocks
  int since_fs = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      since_fs = 0;
    end else begin
      since_fs++;
      if (frame_start) begin
        checks++;
        if (since_fs != FP) begin
          errors++;
          $display("FAIL fs_spacing at %0t: got %0d clocks, expected %0d", $time, since_fs, FP);
        end
        since_fs = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    chk_reset_pins();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_pins();
    #1;
    release_reset();

    // Dark first frame, then 12AF on every digit
    data = 16'h12AF; en = 1'b1;
    run(3 * FP);

    // Mid-frame data change appears only in the following frame
    data = 16'h0000;
    run(FP + FP / 2);
    data = 16'h8888;
    run(2 * FP);

    // Blinking digit 0 with decimal point
    data = 16'h1234; blink_mask = 4'b0001; dp_in = 4'b0001;
    run(8 * FP);
    blink_mask = 4'b0000; dp_in = 4'b0000;

    // Display enable dropped for 10 clocks
    run(5);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(2 * FP);

    // Leading zeros, and a suppressible zero carrying a decimal point
    data = 16'h0050;
    run(3 * FP);
    data = 16'h0000; dp_in = 4'b0100;
    run(3 * FP);
    dp_in = 4'b0000;

    // Reset in the middle of a slot
    run(13);
    mid_reset();
    run(2 * FP + 5);

    // Randomized inputs
    for (int i = 0; i < 40 * FP; i++) begin
      if ($urandom_range(0, 15) == 0) data = 16'($urandom) >> (4 * $urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 31) == 0) blank_mask = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 31) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(0, 40) == 0) en = ~en;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised multiplexed scanner for an N-digit common-anode 7-segment display. It runs from the system clock with an internal refresh prescaler and decodes full hexadecimal (0-F) with a per-digit decimal point. It adds per-digit blanking, per-digit blinking, inter-digit ghosting guard and frame-coherent input capture. It sits between the datapath's display registers and the board's anode/cathode pins.

## Interface

- N_DIGITS, 4, number of digits scanned (1..8)
- CLK_DIV, 100000, clocks per digit slot (>= GUARD+2)
- GUARD, 16, clocks at the start of each slot with all anodes off
- BLINK_FRAMES, 25, frames per blink half-period (>= 1)

Ports:

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  display enable; low forces all anodes off, counters keep running
- data  in  4*N_DIGITS  hex nibbles; digit i = data[4i+3:4i], digit 0 rightmost
- dp_in  in  N_DIGITS  decimal point request per digit, active-high
- blank_mask  in  N_DIGITS  1 = digit dark
- blink_mask  in  N_DIGITS  1 = digit blinks
- an  out  N_DIGITS  anodes, active-low
- seg  out  7  cathodes, active-low, seg[0]=a .. seg[6]=g
- dp  out  1  decimal point cathode, active-low
- frame_start  out  1  one-cycle pulse when inputs are captured

## Operation

- div_cnt counts 0..CLK_DIV-1 and wraps. At div_cnt==CLK_DIV-1, digit_idx advances and wraps from N_DIGITS-1 to 0.
- Snapshot: on the clock where div_cnt==CLK_DIV-1 and digit_idx==N_DIGITS-1, data, dp_in, blank_mask and blink_mask are copied into shadow registers. frame_start is asserted on the following cycle. Only shadow values are ever displayed; input changes mid-frame appear in the next frame.
- Slot phases per digit:
  - GUARD: div_cnt < GUARD. an all ones; seg and dp already carry the new digit's pattern.
  - DRIVE: div_cnt >= GUARD. an = ~(1<<digit_idx) when the digit is visible, else all ones.
- Digit visible = en && !shadow_blank[i] && !(shadow_blink[i] && !blink_phase).
- Blink: blink_cnt counts frame_start pulses 0..BLINK_FRAMES-1. On wrap, blink_phase toggles. blink_phase = 1 means visible.
- Decode uses standard hex glyphs, g..a active-low:
  - 0 = 1000000
  - 1 = 1111001
  - 8 = 0000000
  - A = 0001000
  - F = 0001110
- dp = ~shadow_dp[digit_idx]. It is gated with the anode, so dp has no effect when the digit is dark.
- All outputs are registered, with one clock of latency from counter state.

## Timing

- Reset values:
  - an, seg, dp: all ones
  - frame_start: 0
  - div_cnt, digit_idx, blink_cnt: 0
  - blink_phase: 1
  - shadow_blank: all ones, so the first frame is dark
  - shadow data/dp/blink: 0
- Reset asserted mid-frame: all outputs are forced to reset values immediately (asynchronous). The scan restarts at digit 0 and div_cnt 0 on the first clock after deassertion.
- Frame period = N_DIGITS*CLK_DIV clocks. frame_start is spaced exactly by the frame period.
- en toggling takes effect on an one clock later, with no effect on counters or snapshot timing.
- Simultaneous snapshot and blink wrap: the new blink_phase and new shadow values take effect together from the first slot of the new frame.
- N_DIGITS=1: digit_idx stays 0, and a snapshot occurs every CLK_DIV clocks.

## Configuration

- LEADING_ZERO_SUPPRESS_EN defined: scanning from digit N_DIGITS-1 downward, shadow digits equal to 0 are treated as blanked until the first nonzero digit. Digit 0 is never suppressed. A suppressed digit whose shadow_dp is set stays visible as dp only, with seg all ones.
- Undefined: all digits are shown as decoded, and no extra logic is built.

## Test plan

Parameters for all scenarios: N_DIGITS=4, CLK_DIV=8, GUARD=2, BLINK_FRAMES=2.

1. Reset pulse mid-scan -> an=4'b1111, seg=7'b1111111, dp=1 and frame_start=0 while rst is high. The first frame after release is dark, and the first frame_start comes 32 clocks after release.
2. data=16'h12AF, masks 0, en=1 -> in the frame after the first frame_start:
   - slot 0: an=1110, seg=0001110
   - slot 1: an=1101, seg=0001000
   - slot 2: an=1011, seg=0100100
   - slot 3: an=0111, seg=1111001
   - In every slot, an=1111 for the first 2 clocks.
3. data changed from 16'h0000 to 16'h8888 mid-frame -> the current frame still shows 1000000 on all digits; the next frame shows 0000000.
4. blink_mask=4'b0001, dp_in=4'b0001 -> digit 0 is lit for 2 frames and dark for 2 frames, repeating. dp=0 only while an=1110; other digits are unaffected.
5. en driven low for 10 clocks -> an=1111 one clock after en falls; frame_start spacing stays at 32 clocks.
6. data=16'h0050 with LEADING_ZERO_SUPPRESS_EN defined -> digits 3 and 2 stay dark, and digits 1 and 0 show 5 and 0. With the macro undefined, all four digits are lit.
